sky_tile_draw: RTL and testbench
================================

// Module: sky_tile_draw
// PURPOSE
//  Pixel-pipeline stage that reads the registered 128x128 sky image ROM.
//  Tiles the image across the whole VGA frame, with a vertical scroll offset.
//  Generates the 14-bit ROM address {addry[6:0], addrx[6:0]} from hcount/vcount and consumes the ROM rgb one cycle later.
//  Delays all VGA timing signals so they stay aligned with the pixel colour.
//  Sits between the VGA timing generator and the sprite/foreground draw stages.
// PARAMETERS
//  IMG_BITS   7   log2 of tile edge (128 px); address width = 2*IMG_BITS = 14
//  RGB_W      12  colour width (4:4:4)
//  CNT_W      11  hcount/vcount width
// PORTS
//  clk          in   1      pixel clock; all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  hcount_in    in   11     timing from upstream
//  vcount_in    in   11
//  hsync_in     in   1
//  vsync_in     in   1
//  hblnk_in     in   1
//  vblnk_in     in   1
//  scroll_y     in   7      requested vertical scroll offset (rows)
//  scroll_valid in   1      request strobe; scroll_y sampled when high
//  scroll_ack   out  1      1-cycle pulse when an offset takes effect
//  rom_addr     out  14     to sky ROM address
//  rom_rgb      in   12     from sky ROM (valid 1 cycle after rom_addr)
//  hcount_out   out  11     timing delayed 3 cycles
//  vcount_out   out  11     timing delayed 3 cycles
//  hsync_out    out  1      timing delayed 3 cycles
//  vsync_out    out  1      timing delayed 3 cycles
//  hblnk_out    out  1      timing delayed 3 cycles
//  vblnk_out    out  1      timing delayed 3 cycles
//  rgb_out      out  12     pixel colour aligned with *_out timing
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - All outputs 0, incl. rom_addr and scroll_ack.
//   - scroll_q=0, pending value=0, FSM=IDLE; all pipeline regs 0.
//   - Reset mid-frame flushes the pipeline; outputs restart 3 cycles after release.
//  Pipeline (edge k = edge that samples the inputs)
//   - Edge k: rom_addr <= {(vcount_in[6:0]+scroll_q) mod 128, hcount_in[6:0]}.
//     Timing captured into d1 at the same edge.
//   - Edge k+1: the ROM registers rom_rgb; timing moves d1 -> d2.
//   - Edge k+2: rgb_out <= (hblnk_d2|vblnk_d2) ? 0 : rom_rgb; timing moves d2 -> out.
//   - Latency: exactly 3 registers, identical for rgb and every timing output.
//   - Row add is 7-bit and wraps: vcount 120 + scroll 10 -> addry 2.
//   - Column wraps naturally: hcount 128 -> addrx 0.
//   - rom_addr is also generated during blanking; its colour is masked to 0.
//  Scroll FSM (IDLE, PENDING); frame_edge = vblnk_in & ~vblnk_in_q (rising edge)
//   - IDLE, scroll_valid=1: pend <= scroll_y, go to PENDING.
//   - PENDING, scroll_valid=1 without frame_edge: pend <= scroll_y (last request wins).
//   - PENDING, frame_edge, no scroll_valid: scroll_q <= pend, scroll_ack=1 for 1 cycle, go to IDLE.
//   - PENDING, frame_edge and scroll_valid together:
//     scroll_q <= old pend, ack pulses, pend <= scroll_y, stay PENDING.
//   - IDLE, frame_edge and scroll_valid together: capture only; applied at the next frame_edge.
//   - scroll_q never changes outside frame_edge, so a visible frame has no tearing.
// TESTING
//  1 Reset, scroll 0, hcount=5, vcount=3, no blank
//    -> rom_addr=0x0185 after 1 edge; rgb_out=rom_rgb 3 edges after sampling.
//  2 Scroll req 10 mid-frame -> no change until the vblnk rise.
//    Then scroll_ack pulses once; vcount=120 gives addry=2.
//  3 Two requests (5, then 9) in one frame -> a single ack; scroll_q=9.
//  4 Request coincident with the vblnk rise while PENDING(4), new value 7
//    -> scroll_q=4 and ack; at the next frame scroll_q=7 and ack.
//  5 hblnk=1, rom_rgb=0xFFF -> rgb_out=0x000.
//    hsync/vsync/blank/counts all delayed exactly 3 cycles.
//  6 Assert rst_n=0 mid-line -> all outputs 0 immediately (async).
//    After release, the first valid rgb_out appears 3 cycles later; scroll_q=0.

Source files
------------

// File: rtl/sky_tile_draw_if.sv
// Pixel-stage bundle for sky_tile_draw: upstream timing, scroll request,
// sky ROM address/data and the delayed timing/colour going downstream.
interface sky_tile_draw_if #(
  parameter int IMG_BITS = 7,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 11
);
  logic [CNT_W-1:0]      hcount_in;
  logic [CNT_W-1:0]      vcount_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  hblnk_in;
  logic                  vblnk_in;
  logic [IMG_BITS-1:0]   scroll_y;
  logic                  scroll_valid;
  logic                  scroll_ack;
  logic [2*IMG_BITS-1:0] rom_addr;
  logic [RGB_W-1:0]      rom_rgb;
  logic [CNT_W-1:0]      hcount_out;
  logic [CNT_W-1:0]      vcount_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  hblnk_out;
  logic                  vblnk_out;
  logic [RGB_W-1:0]      rgb_out;

  // Environment side: timing source, scroll requester and sky ROM
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output scroll_y, scroll_valid, rom_rgb,
    input  scroll_ack, rom_addr,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out
  );

  // Draw stage side
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  scroll_y, scroll_valid, rom_rgb,
    output scroll_ack, rom_addr,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out
  );
endinterface

// File: rtl/sky_tile_draw.sv
// Sky background stage: tiles a 128x128 registered ROM image over the frame
// with a vertical scroll offset that only changes at the start of vblank.
// Timing and colour leave the stage with an identical 3-register latency.
module sky_tile_draw #(
  parameter int IMG_BITS = 7,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  sky_tile_draw_if.slave bus
);

  typedef enum logic {IDLE, PENDING} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } timing_t;

  state_t                state;
  logic [IMG_BITS-1:0]   pend;
  logic [IMG_BITS-1:0]   scroll_q;
  logic                  vblnk_in_q;
  logic                  frame_edge;
  logic                  ack_r;

  logic [2*IMG_BITS-1:0] addr_r;
  logic [IMG_BITS-1:0]   addry;
  timing_t               tim_in, d1, d2, tout;
  logic                  v1, v2;
  logic [RGB_W-1:0]      rgb_r;

  // Frame boundary detect and current-pixel timing bundle
  always_comb begin
    frame_edge    = bus.vblnk_in & ~vblnk_in_q;
    addry         = bus.vcount_in[IMG_BITS-1:0] + scroll_q;
    tim_in        = '0;
    tim_in.hcount = bus.hcount_in;
    tim_in.vcount = bus.vcount_in;
    tim_in.hsync  = bus.hsync_in;
    tim_in.vsync  = bus.vsync_in;
    tim_in.hblnk  = bus.hblnk_in;
    tim_in.vblnk  = bus.vblnk_in;
  end

  // Scroll request FSM: latch requests, apply the pending one at vblank rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      scroll_q   <= '0;
      vblnk_in_q <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      vblnk_in_q <= bus.vblnk_in;
      ack_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.scroll_valid) begin
            pend  <= bus.scroll_y;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_edge) begin
            // Old pending value is applied; a coincident request becomes
            // the new pending value for the following frame.
            scroll_q <= pend;
            ack_r    <= 1'b1;
            if (bus.scroll_valid) begin
              pend <= bus.scroll_y;
            end else begin
              state <= IDLE;
            end
          end else if (bus.scroll_valid) begin
            pend <= bus.scroll_y;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address generation, timing delay line and blank-masked colour output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      d1     <= '0;
      d2     <= '0;
      tout   <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      rgb_r  <= '0;
    end else begin
      addr_r <= {addry, bus.hcount_in[IMG_BITS-1:0]};
      d1     <= tim_in;
      v1     <= 1'b1;
      d2     <= d1;
      v2     <= v1;
      tout   <= d2;
      // v2 keeps the ROM word read while in reset from reaching the output
      rgb_r  <= (v2 && !(d2.hblnk || d2.vblnk)) ? bus.rom_rgb : '0;
    end
  end

  assign bus.scroll_ack = ack_r;
  assign bus.rom_addr   = addr_r;
  assign bus.hcount_out = tout.hcount;
  assign bus.vcount_out = tout.vcount;
  assign bus.hsync_out  = tout.hsync;
  assign bus.vsync_out  = tout.vsync;
  assign bus.hblnk_out  = tout.hblnk;
  assign bus.vblnk_out  = tout.vblnk;
  assign bus.rgb_out    = rgb_r;

endmodule

// File: tb/tb_sky_tile_draw.sv
// Bench for sky_tile_draw: directed scroll/blank/reset scenarios followed by
// randomized frames, all checked against a behavioural model of the stage.
module tb_sky_tile_draw;

  logic clk;
  logic rst_n;
  logic force_fff;
  int   errors;
  int   checks;

  sky_tile_draw_if bus ();

  sky_tile_draw dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [13:0] a);
    logic [13:0] t;
    t = a * 14'd37 + 14'd11;
    return t[11:0] ^ {6'd0, t[13:8]};
  endfunction

  // Registered sky ROM
  always @(posedge clk) bus.rom_rgb <= force_fff ? 12'hFFF : rom_f(bus.rom_addr);

  // ---------------- reference model ----------------
  typedef struct {
    logic [13:0] addr;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic        valid;
    logic [11:0] rom;
  } rec_t;

  rec_t p[3];
  rec_t m_new;
  int   m_scroll, m_pend;
  bit   m_have, m_prev_vb, m_ack;
  int   ay, ax;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) p[i] = '{default: '0};
      m_scroll = 0; m_pend = 0; m_have = 0; m_prev_vb = 0; m_ack = 0;
    end else begin
      ay = (int'(bus.vcount_in) + m_scroll) % 128;
      ax = int'(bus.hcount_in) % 128;
      m_new       = '{default: '0};
      m_new.addr  = 14'(ay * 128 + ax);
      m_new.h     = bus.hcount_in;
      m_new.v     = bus.vcount_in;
      m_new.hs    = bus.hsync_in;
      m_new.vs    = bus.vsync_in;
      m_new.hb    = bus.hblnk_in;
      m_new.vb    = bus.vblnk_in;
      m_new.valid = 1'b1;
      m_ack = 0;
      if (bus.vblnk_in && !m_prev_vb && m_have) begin
        m_scroll = m_pend; m_ack = 1; m_have = 0;
      end
      if (bus.scroll_valid) begin
        m_pend = int'(bus.scroll_y); m_have = 1;
      end
      m_prev_vb = bus.vblnk_in;
      p[2] = p[1];
      p[1] = p[0];
      p[0] = m_new;
      p[1].rom = force_fff ? 12'hFFF : rom_f(p[1].addr);
    end
  end

  function automatic logic [31:0] exp_rgb();
    return (p[2].valid && !(p[2].hb || p[2].vb)) ? {20'd0, p[2].rom} : 32'd0;
  endfunction

  function automatic logic [31:0] exp_tim();
    return {6'd0, p[2].h, p[2].v, p[2].hs, p[2].vs, p[2].hb, p[2].vb};
  endfunction

  function automatic logic [31:0] dut_tim();
    return {6'd0, bus.hcount_out, bus.vcount_out,
            bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: outputs are compared on the falling edge after each rising edge
  task automatic cycle();
    @(negedge clk);
    check("rom_addr", {18'd0, bus.rom_addr}, {18'd0, p[0].addr});
    check("rgb_out", {20'd0, bus.rgb_out}, exp_rgb());
    check("scroll_ack", {31'd0, bus.scroll_ack}, {31'd0, m_ack});
    check("timing", dut_tim(), exp_tim());
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb,
                       input bit sv, input int sy);
    bus.hcount_in    = 11'(h);
    bus.vcount_in    = 11'(v);
    bus.hsync_in     = 1'b0;
    bus.vsync_in     = 1'b0;
    bus.hblnk_in     = hb;
    bus.vblnk_in     = vb;
    bus.scroll_valid = sv;
    bus.scroll_y     = 7'(sy);
    cycle();
  endtask

  task automatic run_frames(input int nf, input int req_permille);
    for (int f = 0; f < nf; f++) begin
      for (int v = 0; v < 140; v++) begin
        for (int c = 0; c < 8; c++) begin
          bus.hcount_in    = 11'($urandom_range(0, 2047));
          bus.vcount_in    = 11'(v);
          bus.hblnk_in     = (c >= 6) || ($urandom_range(0, 7) == 0);
          bus.vblnk_in     = (v >= 130);
          bus.hsync_in     = (c == 6);
          bus.vsync_in     = (v == 132) || (v == 133);
          bus.scroll_valid = ($urandom_range(0, 999) < req_permille);
          bus.scroll_y     = 7'($urandom_range(0, 127));
          force_fff        = ($urandom_range(0, 15) == 0);
          cycle();
        end
      end
    end
    force_fff = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; force_fff = 1'b0;
    errors = 0; checks = 0;
    bus.hcount_in = '0; bus.vcount_in = '0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
    bus.scroll_valid = 1'b0; bus.scroll_y = '0;

    // Reset state
    repeat (2) cycle();
    check("rst_rgb", {20'd0, bus.rgb_out}, 32'd0);
    check("rst_addr", {18'd0, bus.rom_addr}, 32'd0);
    rst_n = 1'b1;

    // Basic address and 3-register latency
    drive(5, 3, 0, 0, 0, 0);
    check("t1_addr", {18'd0, bus.rom_addr}, 32'h0185);
    drive(5, 3, 0, 0, 0, 0);
    drive(5, 3, 0, 0, 0, 0);
    check("t1_rgb", {20'd0, bus.rgb_out}, {20'd0, rom_f(14'h0185)});

    // Request 10 mid-frame, applied only at the vblank rise
    drive(0, 50, 0, 0, 1, 10);
    drive(0, 50, 0, 0, 0, 0);
    check("t2_nochange", {25'd0, bus.rom_addr[13:7]}, 32'd50);
    drive(0, 130, 0, 1, 0, 0);
    check("t2_ack", {31'd0, bus.scroll_ack}, 32'd1);
    drive(0, 131, 0, 1, 0, 0);
    check("t2_ack_once", {31'd0, bus.scroll_ack}, 32'd0);
    drive(0, 120, 0, 1, 0, 0);
    check("t2_row_wrap", {25'd0, bus.rom_addr[13:7]}, 32'd2);
    drive(128, 0, 0, 1, 0, 0);
    check("t2_col_wrap", {18'd0, bus.rom_addr}, {18'd0, 7'd10, 7'd0});
    drive(0, 0, 0, 0, 0, 0);

    // Two requests in one frame: last wins, single ack
    drive(1, 10, 0, 0, 1, 5);
    drive(2, 11, 0, 0, 1, 9);
    drive(3, 130, 0, 1, 0, 0);
    check("t3_ack", {31'd0, bus.scroll_ack}, 32'd1);
    drive(4, 131, 0, 1, 0, 0);
    check("t3_ack_once", {31'd0, bus.scroll_ack}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("t3_scroll", {25'd0, bus.rom_addr[13:7]}, 32'd9);

    // Request coincident with vblank rise while pending
    drive(0, 20, 0, 0, 1, 4);
    drive(0, 130, 0, 1, 1, 7);
    check("t4_ack1", {31'd0, bus.scroll_ack}, 32'd1);
    drive(0, 0, 0, 1, 0, 0);
    check("t4_scroll4", {25'd0, bus.rom_addr[13:7]}, 32'd4);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 130, 0, 1, 0, 0);
    check("t4_ack2", {31'd0, bus.scroll_ack}, 32'd1);
    drive(0, 0, 0, 1, 0, 0);
    check("t4_scroll7", {25'd0, bus.rom_addr[13:7]}, 32'd7);
    drive(0, 1, 0, 0, 0, 0);

    // Blank masking and timing delay
    force_fff = 1'b1;
    repeat (3) drive(9, 9, 1, 0, 0, 0);
    check("t5_mask", {20'd0, bus.rgb_out}, 32'd0);
    drive(100, 9, 0, 0, 0, 0);
    drive(101, 9, 0, 0, 0, 0);
    drive(102, 9, 0, 0, 0, 0);
    check("t5_fff", {20'd0, bus.rgb_out}, 32'hFFF);
    check("t5_hdelay", {21'd0, bus.hcount_out}, 32'd100);
    force_fff = 1'b0;

    // Randomized frames
    run_frames(4, 3);

    // Asynchronous reset mid-line
    #3 rst_n = 1'b0;
    #1;
    check("t6_rgb", {20'd0, bus.rgb_out}, 32'd0);
    check("t6_addr", {18'd0, bus.rom_addr}, 32'd0);
    check("t6_ack", {31'd0, bus.scroll_ack}, 32'd0);
    check("t6_tim", dut_tim(), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    drive(7, 5, 0, 0, 0, 0);
    check("t6_scroll0", {18'd0, bus.rom_addr}, {18'd0, 7'd5, 7'd7});
    drive(8, 5, 0, 0, 0, 0);
    check("t6_flush", {20'd0, bus.rgb_out}, 32'd0);
    drive(9, 5, 0, 0, 0, 0);
    check("t6_first_rgb", {20'd0, bus.rgb_out}, {20'd0, rom_f({7'd5, 7'd7})});

    run_frames(3, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
